vga_text_console: RTL and testbench

Parametrised multi-line text console. It keeps a COLS×ROWS character buffer with a cursor and supports four commands: put, backspace, newline with hardware scroll, and clear. It renders the buffer through the shared 5×9 glyph set onto the `curRow`/`curCol` raster from `vga_controller`. It sits between the keypad/charCode source and `vga_controller`, and drives its `buffer_r/g/b` inputs directly.

---
 rtl/vga_text_pkg.sv | 33 +++
 rtl/vga_glyph_rom.sv | 60 ++++++
 rtl/vga_text_console.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_text_console.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared definitions for the text console: command encodings, controller
// states, glyph/cell geometry and a helper that turns row-ordered glyph
// art into the bit order the pixel path indexes.
package vga_text_pkg;

   typedef logic [1:0] cmd_t;

   localparam cmd_t CMD_PUT       = 2'b00;
   localparam cmd_t CMD_BACKSPACE = 2'b01;
   localparam cmd_t CMD_NEWLINE   = 2'b10;
   localparam cmd_t CMD_CLEAR     = 2'b11;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CLR_LINE = 2'd1;
   localparam logic [1:0] ST_CLR_ALL  = 2'd2;

   localparam int GLYPH_W    = 5;
   localparam int GLYPH_H    = 9;
   localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
   localparam int CELL_W     = 8;
   localparam int CELL_H     = 10;

   localparam logic [6:0] CODE_BLANK = 7'd0;

   // Art is written top row first, leftmost column as the MSB of each row.
   // Full reversal lands row r / column c on bit r*GLYPH_W + c.
   function automatic logic [GLYPH_BITS-1:0] art_to_glyph(input logic [GLYPH_BITS-1:0] art);
      logic [GLYPH_BITS-1:0] g;
      for (int i = 0; i < GLYPH_BITS; i++) g[i] = art[GLYPH_BITS-1-i];
      return g;
   endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// Combinational glyph table for the console font.
//   code  in   7-bit character code (0 space, 1-26 A-Z, 27 '!', 28-37 '0'-'9')
//   glyph out  45-bit bitmap, bit row*5+col, row 0 at top, col 0 at left
// Unassigned codes return a solid 5x9 block.
module vga_glyph_rom
   import vga_text_pkg::*;
(
   input  logic [6:0]            code,
   output logic [GLYPH_BITS-1:0] glyph
);

   logic [GLYPH_BITS-1:0] art;

   always_comb begin
      art = '1;
      case (code)
         7'd0:    art = '0;
         7'd1:    art = 45'b11111_10001_10001_10001_11111_10001_10001_10001_10001;
         7'd2:    art = 45'b11110_10001_10001_10001_11110_10001_10001_10001_11110;
         7'd3:    art = 45'b01110_10001_10000_10000_10000_10000_10000_10001_01110;
         7'd4:    art = 45'b11110_10001_10001_10001_10001_10001_10001_10001_11110;
         7'd5:    art = 45'b11111_10000_10000_10000_11110_10000_10000_10000_11111;
         7'd6:    art = 45'b11111_10000_10000_10000_11110_10000_10000_10000_10000;
         7'd7:    art = 45'b01110_10001_10000_10000_10111_10001_10001_10001_01111;
         7'd8:    art = 45'b10001_10001_10001_10001_11111_10001_10001_10001_10001;
         7'd9:    art = 45'b01110_00100_00100_00100_00100_00100_00100_00100_01110;
         7'd10:   art = 45'b00111_00010_00010_00010_00010_00010_10010_10010_01100;
         7'd11:   art = 45'b10001_10010_10100_11000_11000_10100_10010_10001_10001;
         7'd12:   art = 45'b10000_10000_10000_10000_10000_10000_10000_10000_11111;
         7'd13:   art = 45'b10001_11011_10101_10101_10001_10001_10001_10001_10001;
         7'd14:   art = 45'b10001_11001_11001_10101_10101_10011_10011_10001_10001;
         7'd15:   art = 45'b01110_10001_10001_10001_10001_10001_10001_10001_01110;
         7'd16:   art = 45'b11110_10001_10001_10001_11110_10000_10000_10000_10000;
         7'd17:   art = 45'b01110_10001_10001_10001_10001_10101_10011_10001_01111;
         7'd18:   art = 45'b11110_10001_10001_10001_11110_10100_10010_10001_10001;
         7'd19:   art = 45'b01110_10001_10000_10000_01110_00001_00001_10001_01110;
         7'd20:   art = 45'b11111_00100_00100_00100_00100_00100_00100_00100_00100;
         7'd21:   art = 45'b10001_10001_10001_10001_10001_10001_10001_10001_01110;
         7'd22:   art = 45'b10001_10001_10001_10001_10001_10001_01010_01010_00100;
         7'd23:   art = 45'b10001_10001_10001_10001_10101_10101_10101_11011_10001;
         7'd24:   art = 45'b10001_10001_01010_01010_00100_01010_01010_10001_10001;
         7'd25:   art = 45'b10001_10001_01010_01010_00100_00100_00100_00100_00100;
         7'd26:   art = 45'b11111_00001_00010_00010_00100_01000_01000_10000_11111;
         7'd27:   art = 45'b00100_00100_00100_00100_00100_00100_00000_00100_00000;
         7'd28:   art = 45'b01110_10001_10011_10011_10101_11001_11001_10001_01110;
         7'd29:   art = 45'b00100_01100_10100_00100_00100_00100_00100_00100_11111;
         7'd30:   art = 45'b01110_10001_00001_00001_00010_00100_01000_10000_11111;
         7'd31:   art = 45'b01110_10001_00001_00001_00110_00001_00001_10001_01110;
         7'd32:   art = 45'b00010_00110_01010_10010_11111_00010_00010_00010_00010;
         7'd33:   art = 45'b11111_10000_10000_11110_00001_00001_00001_10001_01110;
         7'd34:   art = 45'b01110_10000_10000_11110_10001_10001_10001_10001_01110;
         7'd35:   art = 45'b11111_00001_00010_00010_00100_00100_01000_01000_01000;
         7'd36:   art = 45'b01110_10001_10001_10001_01110_10001_10001_10001_01110;
         7'd37:   art = 45'b01110_10001_10001_10001_01111_00001_00001_00001_01110;
         default: art = '1;
      endcase
      glyph = art_to_glyph(art);
   end

endmodule

// File: rtl/vga_text_console.sv
// Multi-line text console with cursor, hardware scroll and clear, rendered
// onto the vga_controller raster.
//   clk_25, reset        pixel clock, async active-high reset
//   addInput, cmd        command strobe (rising edge) and command code
//   charCode             character written by PUT
//   curRow, curCol       raster position
//   buffer_r/g/b         pixel colour (15 or 0)
//   busy                 a clear sequence is running
//   cursor_row/col       logical cursor position
//
// state       | meaning
// ST_IDLE     | accepting commands
// ST_CLR_LINE | blanking the new bottom line after a scroll, one cell/cycle
// ST_CLR_ALL  | blanking the whole buffer, one cell/cycle
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int ROWS         = 4,
   parameter int SCALE_LOG2   = 2,
   parameter int ORIGIN_X     = 64,
   parameter int ORIGIN_Y     = 200,
   parameter int BLINK_FRAMES = 30
)(
   input  logic                       clk_25,
   input  logic                       reset,
   input  logic                       addInput,
   input  logic [1:0]                 cmd,
   input  logic [6:0]                 charCode,
   input  logic [8:0]                 curRow,
   input  logic [9:0]                 curCol,
   output logic [3:0]                 buffer_r,
   output logic [3:0]                 buffer_g,
   output logic [3:0]                 buffer_b,
   output logic                       busy,
   output logic [$clog2(ROWS)-1:0]    cursor_row,
   output logic [$clog2(COLS+1)-1:0]  cursor_col
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS + 1);
   localparam int NCELL = ROWS * COLS;
   localparam int IDX_W = $clog2(NCELL);
   localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

   logic [6:0]       cells [NCELL];
   logic [ROW_W-1:0] top;
   logic [1:0]       state;
   logic [IDX_W-1:0] clr_idx;
   logic [IDX_W-1:0] clr_cnt;
   logic             add_prev;
   logic             accept;
   logic             newline_req;
   logic             at_last_col;
   logic             at_last_row;
   logic [IDX_W-1:0] cur_idx;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [6:0]       wr_data;
   logic             origin_prev;
   logic             frame_tick;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_on;

   // r is always below 2*ROWS, so one conditional subtract is a full modulo
   function automatic logic [ROW_W-1:0] wrap_row(input int r);
      return (r >= ROWS) ? ROW_W'(r - ROWS) : ROW_W'(r);
   endfunction

   assign busy        = (state != ST_IDLE);
   assign accept      = addInput && !add_prev && (state == ST_IDLE);
   assign at_last_col = (cursor_col == COL_W'(COLS - 1));
   assign at_last_row = (cursor_row == ROW_W'(ROWS - 1));
   assign newline_req = accept && ((cmd == CMD_NEWLINE) || ((cmd == CMD_PUT) && at_last_col));
   assign cur_idx     = IDX_W'(int'(wrap_row(int'(top) + int'(cursor_row))) * COLS + int'(cursor_col));

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cur_idx;
      wr_data = CODE_BLANK;
      if (busy) begin
         wr_en  = 1'b1;
         wr_idx = clr_idx;
      end else if (accept) begin
         if (cmd == CMD_PUT) begin
            wr_en   = 1'b1;
            wr_data = charCode;
         end else if ((cmd == CMD_BACKSPACE) && (cursor_col != '0)) begin
            wr_en  = 1'b1;
            wr_idx = cur_idx - IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCELL; i++) cells[i] <= CODE_BLANK;
      end else if (wr_en) begin
         cells[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cursor_row <= '0;
         cursor_col <= '0;
         top        <= '0;
         clr_idx    <= '0;
         clr_cnt    <= '0;
         add_prev   <= 1'b0;
      end else begin
         add_prev <= addInput;
         case (state)
            ST_IDLE: begin
               if (newline_req) begin
                  cursor_col <= '0;
                  if (!at_last_row) begin
                     cursor_row <= cursor_row + ROW_W'(1);
                  end else begin
                     // the old top line becomes the new bottom line
                     top     <= wrap_row(int'(top) + 1);
                     clr_idx <= IDX_W'(int'(top) * COLS);
                     clr_cnt <= IDX_W'(COLS - 1);
                     state   <= ST_CLR_LINE;
                  end
               end else if (accept) begin
                  case (cmd)
                     CMD_PUT:       cursor_col <= cursor_col + COL_W'(1);
                     CMD_BACKSPACE: if (cursor_col != '0) cursor_col <= cursor_col - COL_W'(1);
                     CMD_CLEAR: begin
                        clr_idx <= '0;
                        clr_cnt <= IDX_W'(NCELL - 1);
                        state   <= ST_CLR_ALL;
                     end
                     default: ;
                  endcase
               end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
               clr_idx <= clr_idx + IDX_W'(1);
               clr_cnt <= clr_cnt - IDX_W'(1);
               if (clr_cnt == '0) begin
                  state <= ST_IDLE;
                  if (state == ST_CLR_ALL) begin
                     cursor_row <= '0;
                     cursor_col <= '0;
                     top        <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Blink timer: one tick per frame, phase flips every BLINK_FRAMES ticks.
   assign frame_tick = (curRow == 9'd0) && (curCol == 10'd0) && !origin_prev;

   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         origin_prev <= 1'b0;
         blink_cnt   <= BLK_W'(BLINK_FRAMES - 1);
         blink_on    <= 1'b0;
      end else begin
         origin_prev <= (curRow == 9'd0) && (curCol == 10'd0);
         if (frame_tick) begin
            if (blink_cnt == '0) begin
               blink_cnt <= BLK_W'(BLINK_FRAMES - 1);
               blink_on  <= !blink_on;
            end else begin
               blink_cnt <= blink_cnt - BLK_W'(1);
            end
         end
      end
   end

   // Pixel path
   int                    px, py, sx, sy, xs, ys, ccol, txt_line, ybase, phys, gbit;
   logic                  in_area;
   logic [IDX_W-1:0]      pix_idx;
   logic [6:0]            pix_code;
   logic [GLYPH_BITS-1:0] glyph;
   logic                  lit;
   logic                  cur_hit;
   logic                  pix_on;

   always_comb begin
      px       = int'(curCol) - ORIGIN_X;
      py       = int'(curRow) - ORIGIN_Y;
      sx       = px >>> SCALE_LOG2;
      sy       = py >>> SCALE_LOG2;
      txt_line = 0;
      ybase    = 0;
      // line boundaries are compile-time multiples of CELL_H; no divider
      for (int k = 1; k < ROWS; k++) begin
         if (sy >= k * CELL_H) begin
            txt_line = k;
            ybase    = k * CELL_H;
         end
      end
      ys      = sy - ybase;
      xs      = sx & (CELL_W - 1);
      ccol    = sx >>> 3;
      in_area = (px >= 0) && (py >= 0) && (sx < COLS * CELL_W) && (sy < ROWS * CELL_H);
      phys    = int'(top) + txt_line;
      if (phys >= ROWS) phys = phys - ROWS;
      pix_idx = in_area ? IDX_W'(phys * COLS + ccol) : '0;
   end

   assign pix_code = cells[pix_idx];

   vga_glyph_rom u_glyph_rom (
      .code  (pix_code),
      .glyph (glyph)
   );

   // glyph occupies columns 3..7 and rows 1..9 of its cell
   always_comb begin
      gbit = (ys - 1) * GLYPH_W + (xs - 3);
      lit  = 1'b0;
      if ((xs >= 3) && (ys >= 1)) lit = glyph[6'(gbit)];
   end

   assign cur_hit  = blink_on && !busy && (txt_line == int'(cursor_row)) && (ccol == int'(cursor_col));
   assign pix_on   = in_area && (lit ^ cur_hit) && !reset;
   assign buffer_r = pix_on ? 4'hF : 4'h0;
   assign buffer_g = pix_on ? 4'hF : 4'h0;
   assign buffer_b = pix_on ? 4'hF : 4'h0;

endmodule

// File: tb/tb_vga_text_console.sv
module tb_vga_text_console;
   import vga_text_pkg::*;

   localparam int COLS         = 16;
   localparam int ROWS         = 4;
   localparam int SCALE_LOG2   = 2;
   localparam int ORIGIN_X     = 64;
   localparam int ORIGIN_Y     = 200;
   localparam int BLINK_FRAMES = 30;
   localparam int SCALE        = 1 << SCALE_LOG2;
   localparam int NCELL        = ROWS * COLS;

   logic       clk_25 = 1'b0;
   logic       reset;
   logic       addInput;
   logic [1:0] cmd;
   logic [6:0] charCode;
   logic [8:0] curRow;
   logic [9:0] curCol;
   logic [3:0] buffer_r, buffer_g, buffer_b;
   logic       busy;
   logic [$clog2(ROWS)-1:0]   cursor_row;
   logic [$clog2(COLS+1)-1:0] cursor_col;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: logical screen lines, scrolling shifts the lines.
   int m_cell [ROWS][COLS];
   int m_row, m_col, m_ticks, m_busy_len;

   vga_text_console #(
      .COLS(COLS), .ROWS(ROWS), .SCALE_LOG2(SCALE_LOG2),
      .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk_25     (clk_25),
      .reset      (reset),
      .addInput   (addInput),
      .cmd        (cmd),
      .charCode   (charCode),
      .curRow     (curRow),
      .curCol     (curCol),
      .buffer_r   (buffer_r),
      .buffer_g   (buffer_g),
      .buffer_b   (buffer_b),
      .busy       (busy),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   always #5 clk_25 = ~clk_25;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int l = 0; l < ROWS; l++)
         for (int c = 0; c < COLS; c++) m_cell[l][c] = 0;
      m_row = 0; m_col = 0; m_ticks = 0; m_busy_len = 0;
   endtask

   task automatic m_newline();
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
      else begin
         for (int l = 0; l < ROWS - 1; l++) m_cell[l] = m_cell[l+1];
         for (int c = 0; c < COLS; c++) m_cell[ROWS-1][c] = 0;
         m_busy_len = COLS;
      end
   endtask

   task automatic m_apply(input logic [1:0] c, input int code);
      m_busy_len = 0;
      case (c)
         CMD_PUT: begin
            m_cell[m_row][m_col] = code;
            m_col++;
            if (m_col == COLS) m_newline();
         end
         CMD_BACKSPACE: if (m_col > 0) begin m_col--; m_cell[m_row][m_col] = 0; end
         CMD_NEWLINE: m_newline();
         default: begin
            for (int l = 0; l < ROWS; l++)
               for (int k = 0; k < COLS; k++) m_cell[l][k] = 0;
            m_row = 0; m_col = 0; m_busy_len = NCELL;
         end
      endcase
   endtask

   function automatic bit m_blink();
      return ((m_ticks / BLINK_FRAMES) % 2) == 1;
   endfunction

   // Expected pixel: 1 lit, 0 dark, -1 when the font detail is not modelled.
   function automatic int exp_pix(input int x, input int y, input bit bsy);
      int sx, sy, c, l, xi, yi, code;
      bit lit, cur;
      if (x < ORIGIN_X || y < ORIGIN_Y) return 0;
      sx = (x - ORIGIN_X) / SCALE;
      sy = (y - ORIGIN_Y) / SCALE;
      c = sx / 8; l = sy / 10;
      if (c >= COLS || l >= ROWS) return 0;
      xi = sx % 8; yi = sy % 10;
      code = m_cell[l][c];
      cur = m_blink() && !bsy && (l == m_row) && (c == m_col);
      if (xi < 3 || yi < 1) lit = 0;
      else if (code == 0) lit = 0;
      else if (code >= 38) lit = 1;
      else if (code == 1 && xi == 3 && yi == 1) lit = 1;
      else return -1;
      return int'(lit ^ cur);
   endfunction

   task automatic pix_chk(input string tag, input int x, input int y, input bit bsy);
      int e;
      @(negedge clk_25);
      curCol = 10'(x); curRow = 9'(y);
      #1;
      e = exp_pix(x, y, bsy);
      if (e >= 0) chk(tag, int'({buffer_r, buffer_g, buffer_b}), (e != 0) ? 'hfff : 0);
   endtask

   task automatic cell_pix(input string tag, input int l, input int c, input int xi, input int yi, input bit bsy);
      pix_chk(tag, ORIGIN_X + (c * 8 + xi) * SCALE + int'($urandom_range(0, SCALE - 1)),
                   ORIGIN_Y + (l * 10 + yi) * SCALE + int'($urandom_range(0, SCALE - 1)), bsy);
   endtask

   task automatic scan_all(input string tag);
      for (int l = 0; l < ROWS; l++)
         for (int c = 0; c < COLS; c++)
            cell_pix(tag, l, c, int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), 1'b0);
   endtask

   task automatic do_cmd(input logic [1:0] c, input int code);
      int n;
      @(negedge clk_25);
      cmd = c; charCode = 7'(code); addInput = 1'b1;
      @(negedge clk_25);
      addInput = 1'b0;
      m_apply(c, code);
      n = 0;
      while (busy === 1'b1 && n < 500) begin n++; @(negedge clk_25); end
      chk("busy_len", n, m_busy_len);
      chk("cursor_row", int'(cursor_row), m_row);
      chk("cursor_col", int'(cursor_col), m_col);
   endtask

   initial begin
      int n, k, code;
      reset = 1'b1; addInput = 1'b0; cmd = 2'b00; charCode = 7'd0;
      curRow = 9'd1; curCol = 10'd1;
      m_reset();
      repeat (3) @(negedge clk_25);
      curCol = 10'(ORIGIN_X + 3 * SCALE); curRow = 9'(ORIGIN_Y + SCALE);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_row", int'(cursor_row), 0);
      chk("rst_col", int'(cursor_col), 0);
      chk("rst_pix", int'({buffer_r, buffer_g, buffer_b}), 0);
      @(negedge clk_25);
      reset = 1'b0;

      // A, B, C
      for (int i = 1; i <= 3; i++) do_cmd(CMD_PUT, i);
      pix_chk("glyph_a_top", ORIGIN_X + 3 * SCALE, ORIGIN_Y + 1 * SCALE, 1'b0);
      cell_pix("glyph_a_margin", 0, 0, 0, 3, 1'b0);
      cell_pix("glyph_blank", 0, 3, 4, 4, 1'b0);

      // full line wraps without scroll; backspace at column 0 is a no-op
      do_cmd(CMD_CLEAR, 0);
      for (int i = 0; i < COLS; i++) do_cmd(CMD_PUT, 28);
      do_cmd(CMD_BACKSPACE, 0);
      scan_all("wrap_scan");

      // fill every line, then scroll via NEWLINE and via last-cell PUT
      do_cmd(CMD_CLEAR, 0);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS - 1; c++) do_cmd(CMD_PUT, ((r + c) % 3 == 0) ? 0 : 38 + r * 20 + c);
         if (r < ROWS - 1) do_cmd(CMD_NEWLINE, 0);
      end
      do_cmd(CMD_NEWLINE, 0);
      scan_all("scroll_nl");
      for (int c = 0; c < COLS; c++) do_cmd(CMD_PUT, 60 + c);
      scan_all("scroll_put");

      // randomized command stream
      for (int i = 0; i < 300; i++) begin
         k = int'($urandom_range(0, 99));
         n = int'($urandom_range(0, 9));
         code = (n == 0) ? 0 : (n == 1) ? 1 : (n == 2) ? 28 : int'($urandom_range(38, 127));
         if (k < 65)      do_cmd(CMD_PUT, code);
         else if (k < 82) do_cmd(CMD_BACKSPACE, 0);
         else if (k < 96) do_cmd(CMD_NEWLINE, 0);
         else             do_cmd(CMD_CLEAR, 0);
         for (int j = 0; j < 3; j++)
            pix_chk("rand_pix", ORIGIN_X - 8 + int'($urandom_range(0, COLS * 32 + 16)),
                                ORIGIN_Y - 8 + int'($urandom_range(0, ROWS * 40 + 16)), 1'b0);
         if (i % 25 == 24) scan_all("rand_scan");
      end

      // CLEAR with an edge during busy that must be dropped
      @(negedge clk_25);
      cmd = CMD_CLEAR; addInput = 1'b1;
      @(negedge clk_25);
      addInput = 1'b0;
      m_apply(CMD_CLEAR, 0);
      n = 0;
      while (busy === 1'b1 && n < 500) begin
         n++;
         if (n == 10) begin cmd = CMD_PUT; charCode = 7'd99; addInput = 1'b1; end
         if (n == 12) addInput = 1'b0;
         @(negedge clk_25);
      end
      chk("clr_busy_len", n, NCELL);
      chk("clr_row", int'(cursor_row), 0);
      chk("clr_col", int'(cursor_col), 0);
      scan_all("clr_scan");

      // unassigned code renders as a solid block
      do_cmd(CMD_PUT, 99);
      for (int y = 0; y < 10; y++)
         for (int x = 0; x < 8; x++) cell_pix("solid_cell", 0, 0, x, y, 1'b0);

      // reset in the middle of a clear
      do_cmd(CMD_NEWLINE, 0);
      for (int c = 0; c < COLS - 1; c++) do_cmd(CMD_PUT, 0);
      do_cmd(CMD_PUT, 99);
      @(negedge clk_25);
      cmd = CMD_CLEAR; addInput = 1'b1;
      @(negedge clk_25);
      addInput = 1'b0;
      cell_pix("pre_rst_pix", 1, COLS - 1, 4, 4, 1'b1);
      repeat (3) @(negedge clk_25);
      #2 reset = 1'b1;
      #1;
      chk("midclr_busy", int'(busy), 0);
      chk("midclr_pix", int'({buffer_r, buffer_g, buffer_b}), 0);
      chk("midclr_row", int'(cursor_row), 0);
      chk("midclr_col", int'(cursor_col), 0);
      @(negedge clk_25);
      reset = 1'b0;
      m_reset();
      do_cmd(CMD_PUT, 99);
      scan_all("post_rst_scan");

      // cursor blink: on after exactly BLINK_FRAMES frame ticks
      for (int i = 1; i <= BLINK_FRAMES; i++) begin
         @(negedge clk_25);
         curRow = 9'd0; curCol = 10'd0;
         @(negedge clk_25);
         curRow = 9'd1; curCol = 10'd1;
         m_ticks++;
         if (i == BLINK_FRAMES - 1) cell_pix("blink_before", 0, 1, 0, 0, 1'b0);
      end
      cell_pix("blink_on_margin", 0, 1, 0, 0, 1'b0);
      cell_pix("blink_on_body", 0, 1, 5, 5, 1'b0);
      cell_pix("blink_other", 0, 0, 0, 0, 1'b0);
      @(negedge clk_25);
      cmd = CMD_CLEAR; addInput = 1'b1;
      @(negedge clk_25);
      addInput = 1'b0;
      cell_pix("blink_busy", 0, 1, 0, 0, 1'b1);
      m_apply(CMD_CLEAR, 0);
      n = 0;
      while (busy === 1'b1 && n < 500) begin n++; @(negedge clk_25); end
      chk("blink_clr_len", n, NCELL - 1);
      cell_pix("blink_after_clr", 0, 0, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
